multicycle_ctrl: RTL and testbench

//  Multicycle RV32I control FSM. Sequences the shared datapath: ALU, extend unit, register file and unified memory.

---
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/multicycle_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the shared datapath/memory.
// master: controller side (drives selects and strobes, reads instruction fields and flags).
// slave: datapath/memory side.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_valid;
  logic       memwrite;
  logic       adrsrc;
  logic       irwrite;
  logic       pcwrite;
  logic       regwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] immsrc;
  logic [2:0] alucontrol;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output mem_valid, memwrite, adrsrc, irwrite, pcwrite, regwrite,
           resultsrc, alusrca, alusrcb, immsrc, alucontrol
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  mem_valid, memwrite, adrsrc, irwrite, pcwrite, regwrite,
           resultsrc, alusrca, alusrcb, immsrc, alucontrol
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM (lw, sw, R-type, I-type ALU, beq, jal).
// Moore selects come from the state register; immsrc/alucontrol decode from the instruction fields.
module multicycle_ctrl #(
  parameter int unsigned CNTW = 32
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   bus,
  output logic                illegal,
  output logic [CNTW-1:0]     instret
);

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpBeq  = 7'b1100011;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
    StExecR, StExecI, StAluWb, StJal, StBeq, StError
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] instret_q;
  logic            retire;
  logic [1:0]      aluop;

  logic       mem_valid, memwrite, adrsrc, irwrite, pcwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;

  // State register and retired-instruction counter; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  // Next state and Moore datapath selects.
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    aluop     = 2'b00;
    mem_valid = 1'b0;
    memwrite  = 1'b0;
    adrsrc    = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    regwrite  = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    illegal   = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_valid = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = bus.mem_ready;
        pcwrite   = bus.mem_ready;
        if (bus.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (bus.opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecR;
          OpI:        state_d = StExecI;
          OpJal:      state_d = StJal;
          OpBeq:      state_d = StBeq;
          default:    state_d = StError;
        endcase
      end
      StMemAdr: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = (bus.opcode == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_valid = 1'b1;
        adrsrc    = 1'b1;
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        mem_valid = 1'b1;
        memwrite  = 1'b1;
        adrsrc    = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExecR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        state_d = StAluWb;
      end
      StExecI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StJal: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
        state_d = StAluWb;
      end
      StBeq: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        pcwrite = bus.zero;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StError: illegal = 1'b1;
      default: state_d = StIdle;
    endcase
  end

  // Field decode for the extend unit and ALU; immsrc forced to 0 where every output must be 0.
  always_comb begin
    immsrc = 2'b00;
    if (state_q != StIdle && state_q != StError) begin
      case (bus.opcode)
        OpSw:    immsrc = 2'b01;
        OpBeq:   immsrc = 2'b10;
        OpJal:   immsrc = 2'b11;
        default: immsrc = 2'b00;
      endcase
    end
    alucontrol = AluAdd;
    case (aluop)
      2'b01: alucontrol = AluSub;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alucontrol = (bus.funct7b5 & bus.opcode[5]) ? AluSub : AluAdd;
          3'b010:  alucontrol = AluSlt;
          3'b110:  alucontrol = AluOr;
          3'b111:  alucontrol = AluAnd;
          default: alucontrol = AluAdd;
        endcase
      end
      default: alucontrol = AluAdd;
    endcase
  end

  assign bus.mem_valid  = mem_valid;
  assign bus.memwrite   = memwrite;
  assign bus.adrsrc     = adrsrc;
  assign bus.irwrite    = irwrite;
  assign bus.pcwrite    = pcwrite;
  assign bus.regwrite   = regwrite;
  assign bus.resultsrc  = resultsrc;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.immsrc     = immsrc;
  assign bus.alucontrol = alucontrol;
  assign instret        = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: the stimulus side walks each instruction through its expected cycle
// sequence and queues the expected outputs; a negedge monitor pops and compares.
module tb_multicycle_ctrl;
  // Narrow counter so random runs cross the wrap point.
  localparam int unsigned CNTW = 4;

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpJal = 7'b1101111;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpSys = 7'b1110011;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            illegal;
  logic [CNTW-1:0] instret;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.CNTW(CNTW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .illegal (illegal),
    .instret (instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            mem_valid;
    logic            memwrite;
    logic            adrsrc;
    logic            irwrite;
    logic            pcwrite;
    logic            regwrite;
    logic [1:0]      resultsrc;
    logic [1:0]      alusrca;
    logic [1:0]      alusrcb;
    logic [1:0]      immsrc;
    logic [2:0]      alucontrol;
    logic            illegal;
    logic [CNTW-1:0] instret;
  } obs_t;

  obs_t            exp_q[$];
  string           tag_q[$];
  int              compared   = 0;
  int              mismatched = 0;
  logic [CNTW-1:0] retired    = '0;

  // Monitor: compare whatever the stimulus side expects for this cycle.
  always @(negedge clk) begin
    obs_t  e, a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a.mem_valid  = bus.mem_valid;
      a.memwrite   = bus.memwrite;
      a.adrsrc     = bus.adrsrc;
      a.irwrite    = bus.irwrite;
      a.pcwrite    = bus.pcwrite;
      a.regwrite   = bus.regwrite;
      a.resultsrc  = bus.resultsrc;
      a.alusrca    = bus.alusrca;
      a.alusrcb    = bus.alusrcb;
      a.immsrc     = bus.immsrc;
      a.alucontrol = bus.alucontrol;
      a.illegal    = illegal;
      a.instret    = instret;
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL %s (check %0d): got %p, required %p", t, compared, a, e);
      end
    end
  end

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == OpSw)  return 2'b01;
    if (op == OpBeq) return 2'b10;
    if (op == OpJal) return 2'b11;
    return 2'b00;
  endfunction

  // ALU operation for register/immediate arithmetic, named first then encoded.
  function automatic logic [2:0] arith_alu(input logic [6:0] op, input logic [2:0] f3,
                                           input logic f7);
    string name;
    name = "add";
    if (f3 == 3'd0 && f7 && op == OpR) name = "sub";
    if (f3 == 3'd2) name = "slt";
    if (f3 == 3'd6) name = "or";
    if (f3 == 3'd7) name = "and";
    if (name == "sub") return 3'b001;
    if (name == "slt") return 3'b101;
    if (name == "or")  return 3'b011;
    if (name == "and") return 3'b010;
    return 3'b000;
  endfunction

  function automatic obs_t quiet();
    obs_t e;
    e = '0;
    e.instret = retired;
    return e;
  endfunction

  function automatic obs_t busy(input logic [6:0] op);
    obs_t e;
    e = quiet();
    e.immsrc = imm_of(op);
    return e;
  endfunction

  task automatic step(input obs_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Memory phase: hold the request through the stall cycles, then complete.
  task automatic mem_phase(input obs_t e, input int stalls, input string t);
    for (int i = 0; i < stalls; i++) begin
      bus.mem_ready = 1'b0;
      bus.zero      = 1'($urandom);
      step(e, {t, "_wait"});
    end
    bus.mem_ready = 1'b1;
    step(e, t);
  endtask

  // kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal opcode, 7 sw aborted by reset.
  task automatic run_instr(input int kind, input logic [2:0] f3, input logic f7,
                           input logic zero_v, input int fstalls, input int mstalls);
    obs_t       e;
    logic [6:0] op;
    case (kind)
      0:       op = OpLw;
      1, 7:    op = OpSw;
      2:       op = OpR;
      3:       op = OpI;
      4:       op = OpBeq;
      5:       op = OpJal;
      default: op = OpSys;
    endcase
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;

    e = busy(op);
    e.mem_valid = 1'b1;
    e.alusrcb   = 2'b10;
    e.resultsrc = 2'b10;
    for (int i = 0; i < fstalls; i++) begin
      bus.mem_ready = 1'b0;
      bus.zero      = 1'($urandom);
      step(e, "fetch_wait");
    end
    bus.mem_ready = 1'b1;
    e.irwrite = 1'b1;
    e.pcwrite = 1'b1;
    step(e, "fetch");

    bus.mem_ready = 1'($urandom);
    e = busy(op);
    e.alusrca = 2'b01;
    e.alusrcb = 2'b01;
    step(e, "decode");

    if (kind <= 1 || kind == 7) begin
      e = busy(op);
      e.alusrca = 2'b10;
      e.alusrcb = 2'b01;
      step(e, "memadr");
    end

    case (kind)
      0: begin
        e = busy(op);
        e.mem_valid = 1'b1;
        e.adrsrc    = 1'b1;
        mem_phase(e, mstalls, "memread");
        bus.mem_ready = 1'($urandom);
        e = busy(op);
        e.resultsrc = 2'b01;
        e.regwrite  = 1'b1;
        step(e, "memwb");
        retired = retired + 1'b1;
      end
      1: begin
        e = busy(op);
        e.mem_valid = 1'b1;
        e.memwrite  = 1'b1;
        e.adrsrc    = 1'b1;
        mem_phase(e, mstalls, "memwrite");
        retired = retired + 1'b1;
      end
      2, 3, 5: begin
        bus.mem_ready = 1'($urandom);
        bus.zero      = 1'($urandom);
        e = busy(op);
        if (kind == 5) begin
          e.alusrca = 2'b01;
          e.alusrcb = 2'b10;
          e.pcwrite = 1'b1;
          step(e, "jal");
        end else begin
          e.alusrca    = 2'b10;
          e.alusrcb    = (kind == 3) ? 2'b01 : 2'b00;
          e.alucontrol = arith_alu(op, f3, f7);
          step(e, (kind == 3) ? "execi" : "execr");
        end
        e = busy(op);
        e.regwrite = 1'b1;
        step(e, "aluwb");
        retired = retired + 1'b1;
      end
      4: begin
        bus.zero = zero_v;
        e = busy(op);
        e.alusrca    = 2'b10;
        e.alucontrol = 3'b001;
        e.pcwrite    = zero_v;
        step(e, "beq");
        retired = retired + 1'b1;
      end
      6: begin
        e = quiet();
        e.illegal = 1'b1;
        for (int i = 0; i < 12; i++) begin
          bus.mem_ready = 1'($urandom);
          bus.zero      = 1'($urandom);
          step(e, "error_hold");
        end
        // Reset cycle still shows ERROR; the following cycle is IDLE with everything clear.
        rst = 1'b1;
        step(e, "error_rst");
        rst     = 1'b0;
        retired = '0;
        step(quiet(), "error_cleared");
      end
      default: begin
        e = busy(op);
        e.mem_valid = 1'b1;
        e.memwrite  = 1'b1;
        e.adrsrc    = 1'b1;
        bus.mem_ready = 1'b0;
        step(e, "abort_wait");
        rst = 1'b1;
        step(e, "abort_rst");
        rst     = 1'b0;
        retired = '0;
        step(quiet(), "abort_idle");
      end
    endcase
  endtask

  initial begin
    bus.opcode    = 7'd0;
    bus.funct3    = 3'd0;
    bus.funct7b5  = 1'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    rst = 1'b1;
    @(posedge clk);
    #1;
    step(quiet(), "reset_hold");
    rst = 1'b0;
    step(quiet(), "idle");

    run_instr(0, 3'd2, 1'b0, 1'b0, 2, 2);   // lw with stalls in FETCH and MEMREAD
    run_instr(2, 3'd0, 1'b1, 1'b0, 0, 0);   // R-type sub
    run_instr(4, 3'd0, 1'b0, 1'b1, 0, 0);   // beq taken
    run_instr(4, 3'd0, 1'b0, 1'b0, 0, 0);   // beq not taken
    run_instr(5, 3'd0, 1'b0, 1'b0, 1, 0);   // jal
    run_instr(3, 3'd0, 1'b1, 1'b0, 0, 0);   // addi with bit 30 set stays add
    run_instr(1, 3'd2, 1'b0, 1'b0, 0, 1);   // sw
    run_instr(6, 3'd0, 1'b0, 1'b0, 0, 0);   // illegal opcode, then reset
    run_instr(0, 3'd2, 1'b0, 1'b0, 0, 0);
    run_instr(7, 3'd2, 1'b0, 1'b0, 0, 0);   // sw aborted by reset mid-access

    for (int n = 0; n < 40; n++) begin
      run_instr(int'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 1'($urandom),
                1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    @(negedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
